// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Multi-cycle control FSM for the turtle-cpu core: fetch, decode,
//            execute/memory, writeback, with halt and bus-timeout fault.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter int                INST_W         = 16,
  parameter logic [INST_W-1:0] HALT_INST      = 16'h0000,
  parameter int                TIMEOUT_CYCLES = 15,
  parameter int                RETIRE_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_enable,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [INST_W-1:0]   imem_rdata,
  output logic [INST_W-1:0]   instruction,
  input  logic                dec_acc_write_enable,
  input  logic                dec_write_put_acc,
  input  logic                dec_status_write_enable,
  input  logic                dec_dmem_write_enable,
  input  logic                dec_dmem_output_enable,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                acc_write_enable,
  output logic                write_put_acc,
  output logic                status_write_enable,
  output logic                pc_update,
  output logic                halted,
  output logic                fault,
  output logic [RETIRE_W-1:0] retired_count
);

  localparam int                  c_wait_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic [INST_W-1:0]   r_instruction;
  logic [RETIRE_W-1:0] r_retired;
  logic                w_waiting;
  logic                w_wait_expired;

  // A request that is still outstanding this cycle accumulates wait time.
  assign w_waiting      = ((r_state == S_FETCH) && !imem_ack) ||
                          ((r_state == S_MEM)   && !dmem_ack);
  assign w_wait_expired = (r_wait_cnt == c_wait_last);

  assign instruction   = r_instruction;
  assign retired_count = r_retired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_instruction <= '0;
      r_retired     <= '0;
    end else begin
      r_state <= w_next;
      if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if ((r_state == S_FETCH) && imem_ack) begin
        r_instruction <= imem_rdata;
      end
      if (r_state == S_WRITEBACK) begin
        r_retired <= r_retired + RETIRE_W'(1);
      end
    end
  end

  always_comb begin
    w_next              = r_state;
    imem_req            = 1'b0;
    dmem_req            = 1'b0;
    dmem_we             = 1'b0;
    acc_write_enable    = 1'b0;
    write_put_acc       = 1'b0;
    status_write_enable = 1'b0;
    pc_update           = 1'b0;
    halted              = 1'b0;
    fault               = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run_enable) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_next = S_DECODE;
        end else if (w_wait_expired) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        if (r_instruction == HALT_INST) begin
          w_next = S_HALTED;
        end else if (dec_dmem_write_enable || dec_dmem_output_enable) begin
          w_next = S_MEM;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        w_next = S_WRITEBACK;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_dmem_write_enable;
        if (dmem_ack) begin
          w_next = S_WRITEBACK;
        end else if (w_wait_expired) begin
          w_next = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        // The only cycle in which architectural state may commit.
        acc_write_enable    = dec_acc_write_enable;
        write_put_acc       = dec_write_put_acc;
        status_write_enable = dec_status_write_enable;
        pc_update           = 1'b1;
        w_next              = run_enable ? S_FETCH : S_IDLE;
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the turtle-cpu core. Fetches each instruction over a req/ack port into an instruction register, which drives the instruction decoder.
- Sequences data-memory accesses and qualifies the decoder's raw write enables, so register, status and memory writes commit in exactly one cycle per instruction.
- Advances the program counter once per retired instruction, stops on a halt instruction, and flags a bus timeout as a fault.

Parameters:
- INST_W, 16, instruction width.
- HALT_INST, 16'h0000, instruction encoding that halts the core.
- TIMEOUT_CYCLES, 15, maximum cycles a request may wait for its ack.
- RETIRE_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- run_enable  input  1  allows starting or continuing instruction fetch.
- imem_req  output  1  instruction fetch request; held until ack.
- imem_ack  input  1  instruction memory has imem_rdata valid.
- imem_rdata  input  INST_W  fetched instruction word.
- instruction  output  INST_W  instruction register; feeds the decoder.
- dec_acc_write_enable  input  1  raw decoder accumulator write.
- dec_write_put_acc  input  1  raw decoder register-file PUT write.
- dec_status_write_enable  input  1  raw decoder status write.
- dec_dmem_write_enable  input  1  decoder: instruction is a STORE.
- dec_dmem_output_enable  input  1  decoder: instruction is a LOAD.
- dmem_req  output  1  data memory request; held until ack.
- dmem_we  output  1  data memory write strobe; valid while dmem_req is high.
- dmem_ack  input  1  data memory access complete.
- acc_write_enable  output  1  qualified accumulator write, one-cycle pulse.
- write_put_acc  output  1  qualified register-file write, one-cycle pulse.
- status_write_enable  output  1  qualified status write, one-cycle pulse.
- pc_update  output  1  PC takes its next value (increment, jump or branch), one-cycle pulse.
- halted  output  1  core is stopped on HALT_INST.
- fault  output  1  a request timed out.
- retired_count  output  RETIRE_W  number of retired instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED, FAULT.
- Reset: state goes to IDLE; instruction=0, retired_count=0, wait counter=0; every output 0.
- Reset wins over all other inputs and aborts any outstanding request: imem_req and dmem_req are 0 in the cycle after rst is sampled high.
- IDLE: if run_enable=1, go to FETCH.
- FETCH:
  - imem_req=1 for as long as the state is held.
  - On a clock edge with imem_ack=1: instruction<=imem_rdata, wait counter cleared, go to DECODE. An ack in the same cycle as the request is legal.
  - Otherwise the wait counter increments. When it reaches TIMEOUT_CYCLES, go to FAULT.
- DECODE: lasts one cycle; the decoder is combinational on instruction.
  - If instruction==HALT_INST, go to HALTED.
  - Else if dec_dmem_write_enable or dec_dmem_output_enable, go to MEM.
  - Else go to EXECUTE.
- EXECUTE: lasts one cycle (ALU settling), then go to WRITEBACK.
- MEM:
  - dmem_req=1 and dmem_we=dec_dmem_write_enable, both held until ack.
  - On dmem_ack=1, go to WRITEBACK.
  - The timeout rule is the same as in FETCH.
- WRITEBACK: lasts one cycle.
  - acc_write_enable, write_put_acc and status_write_enable copy the corresponding dec_* inputs.
  - pc_update=1 and retired_count increments; the counter wraps modulo 2^RETIRE_W.
  - Next state is FETCH if run_enable=1, otherwise IDLE.
- Qualified enables and pc_update are 0 in every state other than WRITEBACK.
- Deassertion of run_enable takes effect only at an instruction boundary (the end of WRITEBACK, or while in IDLE); it never aborts an in-flight request.
- HALTED: halted=1, no requests issued. Only rst exits this state. The PC is not updated for the halt instruction.
- FAULT: fault=1, no requests issued. Only rst exits this state.
- No timeout applies in IDLE, DECODE, EXECUTE or WRITEBACK.
- Latency with zero-wait acks: ALU instruction 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK); memory instruction 4 cycles (FETCH, DECODE, MEM, WRITEBACK). Each cycle of ack delay adds 1 cycle.
- Outputs are registered or decoded from state only. There is no combinational path from ack inputs to req outputs.

Test Plan:
- Reset, then run_enable=1, imem_ack tied high, imem_rdata=ALU op -> imem_req rises 1 cycle after IDLE; acc_write_enable, status_write_enable and pc_update pulse once every 4 cycles; retired_count=3 after 12 cycles.
- STORE instruction, dmem_ack delayed 2 cycles -> dmem_req=1 and dmem_we=1 for 3 cycles; no acc_write_enable; pc_update pulses once; instruction takes 6 cycles.
- LOAD instruction -> dmem_we=0 during MEM; acc_write_enable pulses exactly in WRITEBACK.
- imem_rdata=16'h0000 -> halted=1 two cycles after fetch ack; no pc_update; retired_count unchanged; imem_req stays 0 until rst.
- imem_ack withheld for 15 cycles -> fault=1 and imem_req drops; then rst pulse -> fault=0, state IDLE, retired_count=0.
- rst asserted during MEM wait -> dmem_req=0 the next cycle; all outputs 0. run_enable dropped mid-instruction -> current instruction retires, then the FSM parks in IDLE.
